coherence_bus_ctrl: RTL

- N-processor memory/coherence controller between per-CPU I/D caches and one single-ported RAM.
- Generalises the dual-core controller in three ways: CPUS processors, fair round-robin arbitration on both the instruction and data sides, and blocks of WORDS words.
- Snoops every non-requesting data cache, supplies dirty data cache-to-cache while writing it back to RAM, and broadcasts invalidations.
- Sits at top level between the caches and the RAM model; uses the ramstate encoding from cpu_types_pkg.

---
 rtl/cpu_types_pkg.sv | 48 ++++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/coherence_bus_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg: shared RAM-state encoding, coherence FSM states, RR helper.
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNOOP = 3'd1,
        SWB   = 3'd2,
        LOAD  = 3'd3,
        WB    = 3'd4
    } cc_state_t;

    localparam int RR_MAX = 8;
    localparam int RR_IW  = 3;

    // First set bit of req at or after ptr, wrapping at n; returns ptr if none.
    function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int ptr, input int n);
        int   res;
        int   idx;
        logic found;
        res   = ptr;
        found = 1'b0;
        for (int i = 0; i < RR_MAX; i++) begin
            if (i < n && !found) begin
                idx = (ptr + i) % n;
                if (req[idx[RR_IW-1:0]]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter: round-robin grant index with a pointer that moves past the winner.
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic                 adv_i,
    output logic [$clog2(N)-1:0] grant_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [RR_MAX-1:0] req_w;

    always_comb begin
        req_w          = '0;
        req_w[N-1:0]   = req_i;
        grant_o        = IW'(rr_pick(req_w, int'(ptr_q), N));
        ptr_d          = (grant_o == IW'(N-1)) ? '0 : grant_o + IW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (adv_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/coherence_bus_ctrl.sv
// ============================================================================
// coherence_bus_ctrl: N-CPU snooping I/D memory controller over one RAM port.
// Rev 1.0
// ============================================================================
`default_nettype none

module coherence_bus_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CPUS  = 4,
    parameter int WORDS = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [CPUS-1:0]     iREN,
    input  logic [CPUS*AW-1:0]  iaddr,
    output logic [CPUS-1:0]     iwait,
    output logic [CPUS*DW-1:0]  iload,
    input  logic [CPUS-1:0]     dREN,
    input  logic [CPUS-1:0]     dWEN,
    input  logic [CPUS*AW-1:0]  daddr,
    input  logic [CPUS*DW-1:0]  dstore,
    output logic [CPUS-1:0]     dwait,
    output logic [CPUS*DW-1:0]  dload,
    input  logic [CPUS-1:0]     cctrans,
    input  logic [CPUS-1:0]     ccwrite,
    output logic [CPUS-1:0]     ccwait,
    output logic [CPUS-1:0]     ccinv,
    output logic [CPUS*AW-1:0]  ccsnoopaddr,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [AW-1:0]       ramaddr,
    output logic [DW-1:0]       ramstore,
    input  logic [DW-1:0]       ramload,
    input  logic [1:0]          ramstate
);

    localparam int            IW        = $clog2(CPUS);
    localparam int            BW        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);

    cc_state_t       state_q;
    logic [IW-1:0]   dgrant_q;
    logic [IW-1:0]   supplier_q;
    logic [BW-1:0]   beat_q;

    logic [CPUS-1:0] dreq;
    logic [CPUS-1:0] grant_oh;
    logic [CPUS-1:0] d_arb_req;
    logic [CPUS-1:0] dirty_others;
    logic [IW-1:0]   dirty_idx;
    logic [IW-1:0]   d_pick;
    logic [IW-1:0]   i_pick;
    logic            d_any;
    logic            ram_access;
    logic            xfer_state;
    logic            d_done;
    logic            i_fetch;
    logic            i_done;
    logic [AW-1:0]   daddr_g;
    logic [DW-1:0]   dstore_g;
    logic [DW-1:0]   dstore_s;

    assign dreq       = dREN | dWEN;
    assign d_any      = |dreq;
    assign grant_oh   = CPUS'(1) << dgrant_q;
    assign ram_access = (ramstate == ACCESS);
    assign xfer_state = (state_q == SWB) || (state_q == LOAD) || (state_q == WB);
    assign d_done     = xfer_state && ram_access && (beat_q == LAST_BEAT);
    assign i_fetch    = (state_q == IDLE) && !d_any && (|iREN);
    assign i_done     = i_fetch && ram_access;
    assign daddr_g    = daddr[dgrant_q*AW +: AW];
    assign dstore_g   = dstore[dgrant_q*DW +: DW];
    assign dstore_s   = dstore[supplier_q*DW +: DW];

    // While a transaction is open the data arbiter only sees the owner, so the
    // advance strobe moves the pointer past the CPU actually served.
    assign d_arb_req  = (state_q == IDLE) ? dreq : grant_oh;

    rr_arbiter #(.N(CPUS)) u_darb (
        .clk     (CLK),
        .rst_n   (nRST),
        .req_i   (d_arb_req),
        .adv_i   (d_done),
        .grant_o (d_pick)
    );

    rr_arbiter #(.N(CPUS)) u_iarb (
        .clk     (CLK),
        .rst_n   (nRST),
        .req_i   (iREN),
        .adv_i   (i_done),
        .grant_o (i_pick)
    );

    always_comb begin
        dirty_others = ccwrite & ~grant_oh;
        dirty_idx    = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (dirty_others[j]) begin
                dirty_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            dgrant_q   <= '0;
            supplier_q <= '0;
            beat_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_any) begin
                        dgrant_q <= d_pick;
                        beat_q   <= '0;
                        state_q  <= dWEN[d_pick] ? WB : SNOOP;
                    end
                end
                SNOOP: begin
                    if (|dirty_others) begin
                        supplier_q <= dirty_idx;
                        state_q    <= SWB;
                    end else begin
                        state_q    <= LOAD;
                    end
                end
                SWB, LOAD, WB: begin
                    if (ram_access) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            beat_q  <= beat_q + BW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iload       = '0;
        dload       = '0;
        if (nRST) begin
            for (int c = 0; c < CPUS; c++) begin
                iload[c*DW +: DW] = ramload;
                dload[c*DW +: DW] = ramload;
            end
        end
        case (state_q)
            IDLE: begin
                if (i_fetch) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[i_pick*AW +: AW];
                    if (ram_access) begin
                        iwait[i_pick] = 1'b0;
                    end
                end
            end
            SNOOP: begin
                for (int j = 0; j < CPUS; j++) begin
                    if (j != int'(dgrant_q)) begin
                        ccwait[j]               = 1'b1;
                        ccinv[j]                = cctrans[dgrant_q];
                        ccsnoopaddr[j*AW +: AW] = daddr_g;
                    end
                end
            end
            SWB: begin
                ccwait[supplier_q]                 = 1'b1;
                ccsnoopaddr[supplier_q*AW +: AW]   = daddr_g;
                ramWEN                             = 1'b1;
                ramaddr                            = daddr_g;
                ramstore                           = dstore_s;
                dload[dgrant_q*DW +: DW]           = dstore_s;
                if (ram_access) begin
                    dwait[dgrant_q]   = 1'b0;
                    dwait[supplier_q] = 1'b0;
                end
            end
            LOAD: begin
                ramREN  = 1'b1;
                ramaddr = daddr_g;
                if (ram_access) begin
                    dwait[dgrant_q] = 1'b0;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr_g;
                ramstore = dstore_g;
                if (ram_access) begin
                    dwait[dgrant_q] = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
